// File: rtl/hamming_7_4_decoder_pipe.sv
// rtl/hamming_7_4_decoder_pipe.sv - Hamming(7,4) SEC decoder, 2-stage valid/ready pipeline with saturating stats
module hamming_7_4_decoder_pipe #(
  parameter int P     = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2**P-2:0]    in_msg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2**P-P-2:0]  out_data,
  output logic               out_corrected,
  output logic [P-1:0]       out_syndrome,
  input  logic               cnt_clear,
  output logic [CNT_W-1:0]   word_cnt,
  output logic [CNT_W-1:0]   corr_cnt
);

  localparam int N = 2**P - 1;
  localparam int K = 2**P - P - 1;

  logic         s1_valid;
  logic [N-1:0] s1_msg;
  logic [P-1:0] s1_syn;

  logic         s1_load;
  logic         s2_load;
  logic         out_xfer;
  logic [P-1:0] in_syn;
  logic [N-1:0] fix_msg;
  logic [K-1:0] fix_data;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    in_syn    = '0;
    in_syn[0] = ^{in_msg[0], in_msg[2], in_msg[4], in_msg[6]};
    in_syn[1] = ^{in_msg[1], in_msg[2], in_msg[5], in_msg[6]};
    in_syn[2] = ^{in_msg[3], in_msg[4], in_msg[5], in_msg[6]};
  end

  // The syndrome is the 1-based position of the bad bit, so a nonzero value flips exactly one bit.
  always_comb begin
    fix_msg = s1_msg;
    if (s1_syn != '0)
      fix_msg = s1_msg ^ (N'(1) << (s1_syn - 1'b1));
    fix_data = {fix_msg[6], fix_msg[5], fix_msg[4], fix_msg[2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_msg   <= '0;
      s1_syn   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_msg <= in_msg;
        s1_syn <= in_syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_corrected <= 1'b0;
      out_syndrome  <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data      <= fix_data;
        out_corrected <= (s1_syn != '0);
        out_syndrome  <= s1_syn;
      end
    end
  end

  // Clear beats a same-cycle delivery; counters stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      word_cnt <= '0;
      corr_cnt <= '0;
    end else if (out_xfer) begin
      if (word_cnt != '1)
        word_cnt <= word_cnt + 1'b1;
      if (out_corrected && (corr_cnt != '1))
        corr_cnt <= corr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_7_4_decoder_pipe.sv
// tb/tb_hamming_7_4_decoder_pipe.sv - self-checking bench for hamming_7_4_decoder_pipe
module tb_hamming_7_4_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_msg;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        out_corrected;
  logic [2:0]  out_syndrome;
  logic        cnt_clear;
  logic [15:0] word_cnt;
  logic [15:0] corr_cnt;

  logic        sm_in_ready;
  logic        sm_out_valid;
  logic [3:0]  sm_out_data;
  logic        sm_out_corrected;
  logic [2:0]  sm_out_syndrome;
  logic [3:0]  sm_word_cnt;
  logic [3:0]  sm_corr_cnt;

  always #5 clk = ~clk;

  hamming_7_4_decoder_pipe #(.P(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_corrected(out_corrected), .out_syndrome(out_syndrome),
    .cnt_clear(cnt_clear), .word_cnt(word_cnt), .corr_cnt(corr_cnt)
  );

  hamming_7_4_decoder_pipe #(.P(3), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sm_in_ready), .in_msg(in_msg),
    .out_valid(sm_out_valid), .out_ready(out_ready), .out_data(sm_out_data),
    .out_corrected(sm_out_corrected), .out_syndrome(sm_out_syndrome),
    .cnt_clear(cnt_clear), .word_cnt(sm_word_cnt), .corr_cnt(sm_corr_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Syndrome as the XOR of the 1-based positions of all set bits.
  function automatic logic [7:0] model(input logic [6:0] m);
    logic [2:0] syn;
    logic [6:0] c;
    syn = 3'd0;
    for (int i = 0; i < 7; i++)
      if (m[i]) syn = syn ^ 3'(i + 1);
    c = m;
    if (syn != 3'd0) c[syn - 3'd1] = ~c[syn - 3'd1];
    return {c[6], c[5], c[4], c[2], (syn != 3'd0), syn};
  endfunction

  // Encoder: place data, then choose parity bits so the position-XOR becomes zero.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] m;
    logic [2:0] s;
    m = 7'd0;
    m[2] = d[0]; m[4] = d[1]; m[5] = d[2]; m[6] = d[3];
    s = model(m)[2:0];
    m[0] = s[0]; m[1] = s[1]; m[3] = s[2];
    return m;
  endfunction

  typedef struct {
    logic [7:0] exp;
    logic [3:0] orig;
    bit         has_orig;
  } sb_t;

  sb_t        sb[$];
  logic [3:0] cur_orig = 4'd0;
  bit         cur_has_orig = 1'b0;
  bit         stalled = 1'b0;
  logic [7:0] held;

  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      sb.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_fields", 32'({out_data, out_corrected, out_syndrome}), 32'(held));
      end
      stalled = out_valid && !out_ready;
      held    = {out_data, out_corrected, out_syndrome};
      if (out_valid && out_ready) begin
        n_out++;
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_data", 32'(out_data), 32'(e.exp[7:4]));
          chk("sb_corrected", 32'(out_corrected), 32'(e.exp[3]));
          chk("sb_syndrome", 32'(out_syndrome), 32'(e.exp[2:0]));
          if (e.has_orig) chk("orig_data", 32'(out_data), 32'(e.orig));
        end
      end
      if (in_valid && in_ready) begin
        e.exp = model(in_msg);
        e.orig = cur_orig;
        e.has_orig = cur_has_orig;
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) step();
  endtask

  task automatic send_words(input int n, input int nerr);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_msg   = enc(4'(k)) ^ ((k < nerr) ? 7'(1 << (k % 7)) : 7'd0);
      step();
    end
    drain(4);
  endtask

  typedef struct {
    logic [6:0] msg;
    logic [3:0] data;
    logic       corr;
    logic [2:0] syn;
  } vec_t;

  vec_t tbl[10];
  logic [6:0] clean_msg[3];
  logic [3:0] clean_dat[3];

  initial begin
    int idx, out0, sent, cyc;
    logic [3:0] d;
    int f;

    tbl[0] = '{7'h55, 4'hB, 1'b0, 3'd0};
    tbl[1] = '{7'h00, 4'h0, 1'b0, 3'd0};
    tbl[2] = '{7'h7F, 4'hF, 1'b0, 3'd0};
    tbl[3] = '{7'h54, 4'hB, 1'b1, 3'd1};
    tbl[4] = '{7'h57, 4'hB, 1'b1, 3'd2};
    tbl[5] = '{7'h51, 4'hB, 1'b1, 3'd3};
    tbl[6] = '{7'h5D, 4'hB, 1'b1, 3'd4};
    tbl[7] = '{7'h45, 4'hB, 1'b1, 3'd5};
    tbl[8] = '{7'h75, 4'hB, 1'b1, 3'd6};
    tbl[9] = '{7'h15, 4'hB, 1'b1, 3'd7};
    clean_msg[0] = 7'h55; clean_msg[1] = 7'h00; clean_msg[2] = 7'h7F;
    clean_dat[0] = 4'hB;  clean_dat[1] = 4'h0;  clean_dat[2] = 4'hF;

    rst = 1'b1; in_valid = 1'b0; in_msg = 7'd0; out_ready = 1'b1; cnt_clear = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_corrected", 32'(out_corrected), 32'd0);
    chk("rst_out_syndrome", 32'(out_syndrome), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_corr_cnt", 32'(corr_cnt), 32'd0);

    for (int v = 0; v < 10; v++) begin
      in_valid = 1'b1;
      in_msg   = tbl[v].msg;
      step();
      in_valid = 1'b0;
      chk("tbl_latency_early", 32'(out_valid), 32'd0);
      step();
      chk("tbl_out_valid", 32'(out_valid), 32'd1);
      chk("tbl_data", 32'(out_data), 32'(tbl[v].data));
      chk("tbl_corrected", 32'(out_corrected), 32'(tbl[v].corr));
      chk("tbl_syndrome", 32'(out_syndrome), 32'(tbl[v].syn));
      step();
    end

    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin
        in_valid = 1'b1;
        in_msg   = clean_msg[c];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 1) begin
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_data", 32'(out_data), 32'(clean_dat[c-1]));
        chk("b2b_corrected", 32'(out_corrected), 32'd0);
      end
    end
    drain(3);

    idx = 0;
    out0 = n_out;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 3 && c < 8);
      in_valid  = (idx < 8);
      in_msg    = enc(4'(idx * 3 + 1));
      @(negedge clk);
      if (c == 7) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (in_valid && in_ready) idx++;
      step();
    end
    drain(4);
    chk("bp_accepted", 32'(idx), 32'd8);
    chk("bp_delivered", 32'(n_out - out0), 32'd8);

    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("clr_word_cnt", 32'(word_cnt), 32'd0);
    send_words(10, 4);
    chk("cnt_words", 32'(word_cnt), 32'd10);
    chk("cnt_corr", 32'(corr_cnt), 32'd4);
    in_valid = 1'b1;
    in_msg   = enc(4'd5) ^ 7'h02;
    step();
    in_valid = 1'b0;
    step();
    chk("clr_coinc_valid", 32'(out_valid), 32'd1);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("clr_coinc_word", 32'(word_cnt), 32'd0);
    chk("clr_coinc_corr", 32'(corr_cnt), 32'd0);
    send_words(20, 0);
    chk("sat_small_word", 32'(sm_word_cnt), 32'd15);
    chk("sat_small_corr", 32'(sm_corr_cnt), 32'd0);
    chk("sat_big_word", 32'(word_cnt), 32'd20);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_msg    = enc(4'd1);
    step();
    in_msg    = enc(4'd2);
    step();
    in_valid  = 1'b0;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_word_cnt", 32'(word_cnt), 32'd0);
    chk("mrst_corr_cnt", 32'(corr_cnt), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_msg    = 7'h55;
    step();
    in_valid  = 1'b0;
    chk("mrst_lat_early", 32'(out_valid), 32'd0);
    step();
    chk("mrst_out_valid2", 32'(out_valid), 32'd1);
    chk("mrst_data", 32'(out_data), 32'hB);
    step();
    drain(2);

    sent = 0;
    cyc  = 0;
    cur_has_orig = 1'b1;
    while (sent < 10000 && cyc < 60000) begin
      d = 4'($urandom_range(0, 15));
      f = $urandom_range(0, 7);
      cur_orig  = d;
      in_msg    = enc(d) ^ ((f < 7) ? 7'(1 << f) : 7'd0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      step();
      cyc++;
    end
    drain(6);
    cur_has_orig = 1'b0;
    chk("rand_sent", 32'(sent), 32'd10000);
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
